// File: rtl/moving_avg_filter_pkg.sv
// rtl/moving_avg_filter_pkg.sv - sizing helpers shared by the moving-average filter files
// Purpose: derive window length, pointer width and rounding constant from the
// module parameters so every file sizes things the same way.
// Ports: none (package).
package moving_avg_filter_pkg;

    // Window length N = 2**log2_taps.
    function automatic int taps_of(input int log2_taps);
        return 1 << log2_taps;
    endfunction

    // Running-sum width: one extra bit per doubling of the window.
    function automatic int sum_w_of(input int data_w, input int log2_taps);
        return data_w + log2_taps;
    endfunction

    // Pointer width for a ring of the given depth; a depth-1 ring still gets one bit.
    function automatic int ptr_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Half an LSB of the shifted result, added before the shift for round-half-up.
    function automatic int rnd_const(input int round, input int log2_taps);
        return (round != 0 && log2_taps > 0) ? (1 << (log2_taps - 1)) : 0;
    endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// rtl/mavg_ring_buf.sv - circular sample store that returns the word being overwritten
// Purpose: holds the last DEPTH accepted samples. The word at wr_ptr is the oldest
// sample and is presented on old_data in the same cycle it gets overwritten.
// Ports:
//   CLK100MHZ  in   clock
//   flush      in   returns wr_ptr to 0 (reset or clear)
//   wr_en      in   store wr_data at wr_ptr and advance
//   wr_data    in   sample to store
//   old_valid  in   ring holds DEPTH real samples; otherwise the oldest reads as 0
//   old_data   out  word at wr_ptr (zero while the window is still filling)
module mavg_ring_buf
    import moving_avg_filter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK100MHZ,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              old_valid,
    output logic [DATA_W-1:0] old_data
);

    localparam int PTR_W = ptr_w_of(DEPTH);

    // No reset on the storage: after a flush the pointer restarts at 0 and
    // entries are rewritten in order, so stale words are only ever at or beyond
    // wr_ptr and are masked by old_valid until the window is full again. This
    // keeps the array free of reset/clear fan-out so it can map to RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge CLK100MHZ) begin
        if (flush) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign old_data = old_valid ? mem[wr_ptr] : '0;

endmodule

// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - signed boxcar filter using a running sum over 2**LOG2_TAPS samples
// Purpose: each accepted sample is added to the running sum and the sample leaving
// the window is subtracted; the average is the sum shifted right by LOG2_TAPS.
// Ports:
//   CLK100MHZ  in   sole clock, rising edge
//   reset_n    in   synchronous active-low reset, dominates everything
//   clear      in   synchronous window flush; out_data keeps its value
//   in_valid   in   in_data carries a new sample
//   in_data    in   signed sample, DATA_W bits
//   out_valid  out  one-cycle pulse, out_data updated
//   out_data   out  signed average, held between pulses
//   win_full   out  window holds N real samples since last reset/clear
module moving_avg_filter
    import moving_avg_filter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LOG2_TAPS = 2,
    parameter int ROUND     = 0,
    parameter int WARMUP    = 0
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              win_full
);

    localparam int TAPS  = taps_of(LOG2_TAPS);
    localparam int SUM_W = sum_w_of(DATA_W, LOG2_TAPS);
    localparam int CNT_W = LOG2_TAPS + 1;
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(rnd_const(ROUND, LOG2_TAPS));

    logic                    flush;
    logic                    accept;
    logic                    emit;
    logic                    full_now;
    logic [DATA_W-1:0]       old_raw;
    logic signed [DATA_W-1:0] new_s;
    logic signed [DATA_W-1:0] old_s;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] sum_rnd;
    logic [DATA_W-1:0]       avg;
    logic [CNT_W-1:0]        fill;
    logic [CNT_W-1:0]        fill_next;

    assign flush    = !reset_n || clear;
    assign accept   = in_valid && !flush;
    assign full_now = (fill == CNT_W'(TAPS));

    mavg_ring_buf #(
        .DEPTH  (TAPS),
        .DATA_W (DATA_W)
    ) u_buf (
        .CLK100MHZ (CLK100MHZ),
        .flush     (flush),
        .wr_en     (accept),
        .wr_data   (in_data),
        .old_valid (full_now),
        .old_data  (old_raw)
    );

    assign new_s = in_data;
    assign old_s = old_raw;

    // Size casts of signed operands sign-extend. The sum cannot leave SUM_W
    // bits, so wrap in the intermediate add is harmless.
    assign sum_next  = sum + SUM_W'(new_s) - SUM_W'(old_s);
    assign sum_rnd   = sum_next + RND;
    // Result fits DATA_W by construction, even with the rounding bias added.
    assign avg       = DATA_W'(sum_rnd >>> LOG2_TAPS);
    assign fill_next = full_now ? fill : fill + 1'b1;
    assign emit      = accept && ((WARMUP == 0) || (fill_next == CNT_W'(TAPS)));

    always_ff @(posedge CLK100MHZ) begin
        if (!reset_n) begin
            sum       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            win_full  <= 1'b0;
        end else if (clear) begin
            sum       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            win_full  <= 1'b0;
        end else begin
            out_valid <= emit;
            if (in_valid) begin
                sum      <= sum_next;
                fill     <= fill_next;
                win_full <= (fill_next == CNT_W'(TAPS));
            end
            if (emit) begin
                out_data <= avg;
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_filter.sv
// tb/tb_moving_avg_filter.sv - scoreboard bench running several filter configurations on one stimulus stream
`timescale 1ns/1ps
module tb_moving_avg_filter;

    localparam int NCFG = 6;

    function automatic int cfg_dw(input int i);
        case (i)
            0, 1, 2: return 8;
            3:       return 6;
            4:       return 10;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_l2(input int i);
        case (i)
            0, 1:    return 2;
            2:       return 3;
            3:       return 0;
            4:       return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_rn(input int i);
        return (i == 1 || i == 4 || i == 5) ? 1 : 0;
    endfunction

    function automatic int cfg_wu(input int i);
        return (i == 2 || i == 4) ? 1 : 0;
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    logic        CLK100MHZ = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    bit          checking = 1'b0;
    int          ntests = 0;
    int          nfail = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g
        localparam int DW = cfg_dw(gi);
        localparam int L2 = cfg_l2(gi);
        localparam int RN = cfg_rn(gi);
        localparam int WU = cfg_wu(gi);
        localparam int N  = 1 << L2;
        localparam int RB = (RN != 0 && N > 1) ? N / 2 : 0;

        logic          ov;
        logic          wf;
        logic [DW-1:0] od;
        int            win[$];
        int            expq[$];
        int            exp_hold = 0;
        bit            exp_full = 1'b0;

        moving_avg_filter #(
            .DATA_W    (DW),
            .LOG2_TAPS (L2),
            .ROUND     (RN),
            .WARMUP    (WU)
        ) dut (
            .CLK100MHZ (CLK100MHZ),
            .reset_n   (reset_n),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_data   (in_data[DW-1:0]),
            .out_valid (ov),
            .out_data  (od),
            .win_full  (wf)
        );

        // Reference: keep the last N accepted samples; the average is the
        // floor of (window total [+ N/2]) / N, with missing samples counting as 0.
        always @(posedge CLK100MHZ) begin
            logic signed [DW-1:0] xs;
            int s;
            int e;
            if (!reset_n) begin
                win.delete();
                exp_full = 1'b0;
                exp_hold = 0;
            end else if (clear) begin
                win.delete();
                exp_full = 1'b0;
            end else if (in_valid) begin
                xs = in_data[DW-1:0];
                win.push_back(int'(xs));
                if (win.size() > N) void'(win.pop_front());
                exp_full = (win.size() == N);
                if (WU == 0 || exp_full) begin
                    s = 0;
                    foreach (win[k]) s += win[k];
                    e = floor_div(s + RB, N);
                    exp_hold = e;
                    expq.push_back(e);
                end
            end
        end

        always @(negedge CLK100MHZ) begin
            logic signed [DW-1:0] ods;
            bit                   want;
            if (checking) begin
                ods  = od;
                want = (expq.size() != 0);
                chk($sformatf("cfg%0d_valid", gi), int'(ov), int'(want));
                if (ov && want) begin
                    chk($sformatf("cfg%0d_data", gi), int'(ods), expq.pop_front());
                end else begin
                    expq.delete();
                    chk($sformatf("cfg%0d_hold", gi), int'(ods), exp_hold);
                end
                chk($sformatf("cfg%0d_win_full", gi), int'(wf), int'(exp_full));
            end
        end
    end

    task automatic drive(input bit v, input int d, input bit clr = 1'b0, input bit rstn = 1'b1);
        @(negedge CLK100MHZ);
        in_valid = v;
        in_data  = 16'(d);
        clear    = clr;
        reset_n  = rstn;
        @(posedge CLK100MHZ);
        #1;
    endtask

    initial begin
        int r;
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        checking = 1'b1;
        chk("reset_valid", int'(g[0].ov), 0);
        chk("reset_data", int'($signed(g[0].od)), 0);
        chk("reset_win_full", int'(g[0].wf), 0);

        // Fill the default window: partial sums over 4.
        drive(1, 4);  chk("t1_out1", int'($signed(g[0].od)), 1);
        chk("t1_valid1", int'(g[0].ov), 1);
        drive(1, 8);  chk("t1_out2", int'($signed(g[0].od)), 3);
        drive(1, 12); chk("t1_out3", int'($signed(g[0].od)), 6);
        chk("t1_not_full", int'(g[0].wf), 0);
        drive(1, 16); chk("t1_out4", int'($signed(g[0].od)), 10);
        chk("t1_full", int'(g[0].wf), 1);

        // Oldest sample drops out; idle cycles hold the result.
        drive(1, 20); chk("t2_out5", int'($signed(g[0].od)), 14);
        for (int k = 0; k < 3; k++) begin
            drive(0, 99);
            chk("t2_idle_valid", int'(g[0].ov), 0);
            chk("t2_idle_hold", int'($signed(g[0].od)), 14);
        end

        // Signed extremes and rounding.
        drive(0, 0, 1);
        for (int k = 0; k < 4; k++) drive(1, -128);
        chk("t3_min_round", int'($signed(g[1].od)), -128);
        chk("t3_min_trunc", int'($signed(g[0].od)), -128);
        for (int k = 0; k < 4; k++) drive(1, 127);
        chk("t3_max_round", int'($signed(g[1].od)), 127);
        chk("t3_max_trunc", int'($signed(g[0].od)), 127);
        drive(1, -1); drive(1, -2); drive(1, 0); drive(1, 0);
        chk("t3_neg_round", int'($signed(g[1].od)), -1);
        chk("t3_neg_trunc", int'($signed(g[0].od)), -1);

        // Warm-up hold-off on the 8-tap configuration.
        drive(0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 10 * k);
            if (k < 8) chk("t4_warm_valid", int'(g[2].ov), 0);
        end
        chk("t4_first_valid", int'(g[2].ov), 1);
        chk("t4_mean8", int'($signed(g[2].od)), 45);

        // Clear beats a same-cycle sample; next output uses a fresh window.
        drive(1, 100, 1);
        chk("t5_clear_valid", int'(g[0].ov), 0);
        chk("t5_clear_full", int'(g[0].wf), 0);
        chk("t5_clear_hold", int'($signed(g[0].od)), 65);
        drive(1, 40);
        chk("t5_after_clear", int'($signed(g[0].od)), 10);

        // Reset mid-burst.
        drive(1, 50); drive(1, 60);
        drive(1, 70, 0, 0);
        chk("t6_rst_valid", int'(g[0].ov), 0);
        chk("t6_rst_data", int'($signed(g[0].od)), 0);
        chk("t6_rst_full", int'(g[0].wf), 0);

        // Random stream with occasional clears and resets.
        for (int i = 0; i < 10000 && nfail <= 50; i++) begin
            r = int'($urandom_range(4999));
            drive($urandom_range(3) != 0, int'($urandom), r < 3, r != 4999);
        end
        drive(0, 0);
        drive(0, 0);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
